// File: rtl/alu_pkg.sv
// Shared definitions for the auto-cycling 8-bit ALU and its result checker.
//
// Contents:
//   alu_op_e      - op encoding shared by the ALU and the checker (SUM..SHR)
//   OP_LAST       - highest op index; the ALU wraps from here back to OP_SUM
//   NUM_OPS       - number of ops / width of the candidate match vector
//   chk_state_e   - checker state (HUNT, LOCKED)
//   next_op()     - op that follows a given op in the 0..5 cycle
//   onehot_idx()  - index of the set bit in a one-hot match vector
package alu_pkg;

  typedef enum logic [2:0] {
    OP_SUM = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SHL = 3'd4,
    OP_SHR = 3'd5
  } alu_op_e;

  localparam logic [2:0] OP_LAST = 3'd5;
  localparam int unsigned NUM_OPS = 6;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  function automatic logic [2:0] next_op(input logic [2:0] op);
    return (op == OP_LAST) ? 3'd0 : op + 3'd1;
  endfunction

  // Caller guarantees m is one-hot; the lowest set bit wins otherwise.
  function automatic logic [2:0] onehot_idx(input logic [NUM_OPS-1:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alu_candidates.sv
// Combinational reference for the ALU: computes every op's result for the given
// operands and flags which of them equal the observed result.
//
// Ports:
//   a, b   in  8  operands
//   r      in  8  observed result
//   match  out 6  match[i] set when op i applied to a/b yields r (all mod 256)
module alu_candidates
  import alu_pkg::*;
(
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  input  logic [7:0]         r,
  output logic [NUM_OPS-1:0] match
);

  logic [7:0] cand [NUM_OPS];

  always_comb begin
    cand[OP_SUM] = a + b;
    cand[OP_SUB] = a - b;
    cand[OP_AND] = a & b;
    cand[OP_OR]  = a | b;
    cand[OP_SHL] = {a[6:0], 1'b0};
    cand[OP_SHR] = {1'b0, a[7:1]};
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      match[i] = (cand[i] == r);
    end
  end

endmodule

// File: rtl/alu_result_checker.sv
// Observer for the auto-cycling ALU output stream. Recovers the op currently
// applied, follows the 0->5->0 sequence and flags results explained by neither
// the current nor the next op.
//
// Parameters:
//   ERR_LIMIT  consecutive unexplained samples in LOCKED before returning to HUNT
//   PERIOD_W   width of the dwell-period counter and last_period
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     a/b/r valid this cycle
//   a, b, r      ALU operands and result
//   op_est       recovered op index
//   locked       high while LOCKED
//   mismatch     one-cycle pulse on an unexplained sample while LOCKED
//   lost         one-cycle pulse on LOCKED->HUNT
//   err_count    saturating count of mismatch pulses
//   last_period  clk cycles between the last two op transitions
//
// Build option: define ALU_CHECK_PERIOD_EN to build the dwell-period counter;
// otherwise last_period is tied to zero.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int unsigned ERR_LIMIT = 3,
  parameter int unsigned PERIOD_W  = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [7:0]          a,
  input  logic [7:0]          b,
  input  logic [7:0]          r,
  output logic [2:0]          op_est,
  output logic                locked,
  output logic                mismatch,
  output logic                lost,
  output logic [7:0]          err_count,
  output logic [PERIOD_W-1:0] last_period
);

  logic [NUM_OPS-1:0] match;

  alu_candidates u_candidates (
    .a     (a),
    .b     (b),
    .r     (r),
    .match (match)
  );

  chk_state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] consec_q, consec_d;
  logic [7:0] err_q, err_d;
  logic       mismatch_q, mismatch_d;
  logic       lost_q, lost_d;
  logic       lock_evt;   // HUNT -> LOCKED this cycle
  logic       trans_evt;  // op advanced to its successor this cycle
  logic [2:0] nxt;
  logic       cur_hit;
  logic       nxt_hit;

  assign nxt     = next_op(op_q);
  // op_q never exceeds OP_LAST; the guard keeps the index in range regardless.
  assign cur_hit = (op_q <= OP_LAST) ? match[op_q] : 1'b0;
  assign nxt_hit = match[nxt];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    consec_d   = consec_q;
    err_d      = err_q;
    mismatch_d = 1'b0;
    lost_d     = 1'b0;
    lock_evt   = 1'b0;
    trans_evt  = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          // Zero or several matches are ambiguous; keep hunting silently.
          if ($onehot(match)) begin
            op_d     = onehot_idx(match);
            state_d  = LOCKED;
            consec_d = '0;
            lock_evt = 1'b1;
          end
        end
        LOCKED: begin
          if (cur_hit) begin
            consec_d = '0;
          end else if (nxt_hit) begin
            op_d      = nxt;
            consec_d  = '0;
            trans_evt = 1'b1;
          end else begin
            mismatch_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            consec_d = consec_q + 4'd1;
            if (consec_q + 4'd1 == 4'(ERR_LIMIT)) begin
              state_d  = HUNT;
              lost_d   = 1'b1;
              consec_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      op_q       <= '0;
      consec_q   <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      consec_q   <= consec_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      lost_q     <= lost_d;
    end
  end

  assign op_est    = op_q;
  assign locked    = (state_q == LOCKED);
  assign mismatch  = mismatch_q;
  assign lost      = lost_q;
  assign err_count = err_q;

`ifdef ALU_CHECK_PERIOD_EN
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] last_period_q, last_period_d;

  always_comb begin
    period_d      = period_q;
    last_period_d = last_period_q;
    // Counts every clk while LOCKED, sampled or not.
    if (state_q == LOCKED && period_q != '1) period_d = period_q + 1'b1;
    if (lock_evt) period_d = '0;
    if (trans_evt) begin
      // +1 accounts for the transition cycle itself.
      last_period_d = (period_q == '1) ? period_q : period_q + 1'b1;
      period_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_q      <= '0;
      last_period_q <= '0;
    end else begin
      period_q      <= period_d;
      last_period_q <= last_period_d;
    end
  end

  assign last_period = last_period_q;
`else
  logic unused_evt;
  assign unused_evt  = lock_evt ^ trans_evt;
  assign last_period = '0;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;

  localparam int unsigned PW = 27;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    a;
  logic [7:0]    b;
  logic [7:0]    r;
  logic [2:0]    op_est;
  logic          locked;
  logic          mismatch;
  logic          lost;
  logic [7:0]    err_count;
  logic [PW-1:0] last_period;

  typedef struct packed {
    logic [2:0] op;
    logic       lck;
    logic       mm;
    logic       lst;
    logic [7:0] err;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  alu_result_checker #(
    .ERR_LIMIT (3),
    .PERIOD_W  (PW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .r           (r),
    .op_est      (op_est),
    .locked      (locked),
    .mismatch    (mismatch),
    .lost        (lost),
    .err_count   (err_count),
    .last_period (last_period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] op, input logic lck, input logic mm,
                              input logic lst, input logic [7:0] err);
    exp_t e;
    e.op = op; e.lck = lck; e.mm = mm; e.lst = lst; e.err = err;
    return e;
  endfunction

  // Drive one sample, push its expected outcome, compare one edge later.
  task automatic step(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                      input logic [7:0] ir, input exp_t e, input string tag);
    exp_t got;
    @(negedge clk);
    in_valid = v; a = ia; b = ib; r = ir;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      cmp({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = q.pop_front();
      cmp({tag, "_op_est"}, 32'(op_est), 32'(got.op));
      cmp({tag, "_locked"}, 32'(locked), 32'(got.lck));
      cmp({tag, "_mismatch"}, 32'(mismatch), 32'(got.mm));
      cmp({tag, "_lost"}, 32'(lost), 32'(got.lst));
      cmp({tag, "_err_count"}, 32'(err_count), 32'(got.err));
    end
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_op_est"}, 32'(op_est), 32'd0);
    cmp({tag, "_locked"}, 32'(locked), 32'd0);
    cmp({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    cmp({tag, "_lost"}, 32'(lost), 32'd0);
    cmp({tag, "_err_count"}, 32'(err_count), 32'd0);
    cmp({tag, "_last_period"}, 32'(last_period), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; r = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Lock on SUM, then walk the full op cycle and wrap.
    step(1, 8'h0F, 8'h01, 8'h10, mk(3'd0, 1, 0, 0, 8'd0), "lock_sum");
    step(1, 8'h0F, 8'h01, 8'h0E, mk(3'd1, 1, 0, 0, 8'd0), "walk_sub");
    step(1, 8'h0F, 8'h01, 8'h01, mk(3'd2, 1, 0, 0, 8'd0), "walk_and");
    step(1, 8'h0F, 8'h01, 8'h0F, mk(3'd3, 1, 0, 0, 8'd0), "walk_or");
    step(1, 8'h0F, 8'h01, 8'h1E, mk(3'd4, 1, 0, 0, 8'd0), "walk_shl");
    step(1, 8'h0F, 8'h01, 8'h07, mk(3'd5, 1, 0, 0, 8'd0), "walk_shr");
    step(1, 8'h0F, 8'h01, 8'h10, mk(3'd0, 1, 0, 0, 8'd0), "wrap_sum");
    // Current op has priority; a repeat stays put.
    step(1, 8'h0F, 8'h01, 8'h10, mk(3'd0, 1, 0, 0, 8'd0), "hold_sum");
    step(1, 8'h0F, 8'h01, 8'h0E, mk(3'd1, 1, 0, 0, 8'd0), "to_sub");

    // Three unexplained samples: lost arrives with the third mismatch.
    step(1, 8'h0F, 8'h01, 8'hAA, mk(3'd1, 1, 1, 0, 8'd1), "err1");
    step(1, 8'h0F, 8'h01, 8'hAA, mk(3'd1, 1, 1, 0, 8'd2), "err2");
    step(1, 8'h0F, 8'h01, 8'hAA, mk(3'd1, 0, 1, 1, 8'd3), "err3_lost");
    step(1, 8'h0F, 8'h01, 8'hAA, mk(3'd1, 0, 0, 0, 8'd3), "hunt_nomatch");

    // All-zero sample matches every op: ambiguous, stays in HUNT.
    step(1, 8'h00, 8'h00, 8'h00, mk(3'd1, 0, 0, 0, 8'd3), "hunt_ambig");

    // Relock on AND, then a skip 2->4 is a mismatch, not a resync.
    step(1, 8'h0F, 8'h01, 8'h01, mk(3'd2, 1, 0, 0, 8'd3), "relock_and");
    step(1, 8'h0F, 8'h01, 8'h1E, mk(3'd2, 1, 1, 0, 8'd4), "skip_mm");
    step(1, 8'h0F, 8'h01, 8'h0F, mk(3'd3, 1, 0, 0, 8'd4), "recover_or");
    step(1, 8'h0F, 8'h01, 8'hAA, mk(3'd3, 1, 1, 0, 8'd5), "err5");
    step(0, 8'h00, 8'h00, 8'hAA, mk(3'd3, 1, 0, 0, 8'd5), "idle");

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Dwell period: SUB arrives 1000 cycles after locking on SUM.
    step(1, 8'h0F, 8'h01, 8'h10, mk(3'd0, 1, 0, 0, 8'd0), "plock");
    for (int i = 0; i < 999; i++) begin
      step(1, 8'h0F, 8'h01, 8'h10, mk(3'd0, 1, 0, 0, 8'd0), "pdwell");
    end
    step(1, 8'h0F, 8'h01, 8'h0E, mk(3'd1, 1, 0, 0, 8'd0), "ptrans");
`ifdef ALU_CHECK_PERIOD_EN
    cmp("last_period", 32'(last_period), 32'd1000);
`else
    cmp("last_period", 32'(last_period), 32'd0);
`endif

    cmp("sb_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Observer for the auto-cycling 8-bit ALU output stream. Samples operands A/B and result R, recovers which operation (SUM, SUB, AND, OR, SHL, SHR) the ALU is currently applying, and tracks the op sequence 0→5→0. It flags results that match neither the current nor the next op, and can measure the dwell period of each op. It sits at the receiving end of the ALU pins, either on the board-level test harness or alongside the ALU in the same tile for self-check.

## Interface
- ERR_LIMIT, 3: consecutive unexplained samples in LOCKED before dropping back to HUNT (range 1..15).
- PERIOD_W, 27: width of the dwell-period counter and `last_period`.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  sample strobe: a/b/r are valid this cycle
- a  in  8  ALU operand A
- b  in  8  ALU operand B
- r  in  8  ALU result
- op_est  out  3  recovered op index 0..5, reset 0
- locked  out  1  high in LOCKED state, reset 0
- mismatch  out  1  one-cycle pulse on an unexplained sample while LOCKED, reset 0
- lost  out  1  one-cycle pulse on the LOCKED→HUNT transition, reset 0
- err_count  out  8  saturating count of mismatch pulses, reset 0
- last_period  out  PERIOD_W  clk cycles between the last two op transitions, reset 0

## Operation
- Candidate results, all mod 256: 0 = a+b; 1 = a−b (two's complement); 2 = a&b; 3 = a|b; 4 = a<<1 with zero fill; 5 = a>>1 logical. `match[5:0]` is set for each candidate equal to r.
- Next op: nxt = (op_est==5) ? 0 : op_est+1.
- HUNT:
  - On in_valid with match one-hot: op_est ← index, go LOCKED, consecutive-error count ← 0, period counter ← 0.
  - On zero or multiple matches: stay in HUNT. This is an ambiguous sample; no mismatch is raised.
- LOCKED, on in_valid:
  - match[op_est]: stay; consecutive-error count ← 0. The current op takes priority even if nxt also matches.
  - else match[nxt]: op_est ← nxt (this is a transition); consecutive-error count ← 0.
  - else: mismatch pulse; err_count += 1, saturating at 255; consecutive-error count += 1.
  - When the consecutive-error count reaches ERR_LIMIT: go HUNT, pulse `lost`, locked ← 0. op_est holds its last value.
- in_valid low: no state change, except the period counter still advances.
- A transition that skips an op (e.g. 2→4) is a mismatch, not a resync.

## Timing
- One-cycle latency: all outputs are registered and reflect the sample one clk edge after in_valid.
- mismatch and lost are exactly one cycle wide. On the final error, mismatch and lost pulse in the same cycle.
- Reset mid-operation: all outputs and state return to reset values asynchronously. HUNT resumes on the first sample after rst_n deasserts.
- Back-to-back in_valid every cycle is supported; there is no backpressure.

## Configuration
- ALU_CHECK_PERIOD_EN defined:
  - The period counter increments every clk while LOCKED and saturates at all-ones.
  - On each transition, last_period ← counter+1 and the counter ← 0.
  - Entering LOCKED clears the counter without updating last_period.
- ALU_CHECK_PERIOD_EN undefined: no counter is built and last_period is tied to 0.

## Structure
- Shared package `alu_pkg`:
  - Op enum: OP_SUM=0, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR=5.
  - OP_LAST=5.
  - Checker state enum {HUNT, LOCKED}.
  - The ALU itself uses the same op enum.
- Sub-module `alu_candidates`: purely combinational. Takes a, b, r and produces match[5:0]. It is reusable by the ALU testbench as a reference model.

## Test plan
- Reset, then in_valid with a=0x0F, b=0x01, r=0x10 → next cycle locked=1, op_est=0, err_count=0.
- Locked at op 0, then sample r=0x0E (SUB) → op_est=1, no mismatch. Continue through r=0x01, 0x0F, 0x1E, 0x07, then 0x10 → op_est walks 2,3,4,5 and wraps to 0.
- In HUNT, sample a=0x00, b=0x00, r=0x00 (all six match) → stays in HUNT, locked=0, no mismatch.
- Locked at op 1 (a=0x0F, b=0x01), three samples with r=0xAA → three mismatch pulses, err_count=3, lost pulses together with the third mismatch, locked=0.
- With ALU_CHECK_PERIOD_EN: locked at op 0, in_valid every cycle, r switches to the SUB result after 1000 cycles → last_period=1000.
- Assert rst_n low while LOCKED with err_count=5 → all outputs 0 immediately, without waiting for a clk edge.
